ad_ip_jesd204_tpl_adc_pack: RTL and testbench

// - Downstream stage of the JESD204 TPL ADC core. Takes the per-beat formatted data of all converter channels and packs only the enabled channels into full-width words for the DMA.
// - Enabled channels are compacted and sample-interleaved. Beats are accumulated until one DMA_DATA_WIDTH word is full.
// - The word is presented on a valid/ready interface. Drops are flagged with a sticky overflow.

---
 rtl/ad_ip_jesd204_tpl_adc_pack_compact.sv | 50 +++++
 rtl/ad_ip_jesd204_tpl_adc_pack.sv | 137 +++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_pack.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_pack_compact.sv
// Stage-1 compaction: gathers the enabled channels of one beat into an LSB-aligned,
// sample-interleaved chunk and registers it together with a chunk-valid flag.
module ad_ip_jesd204_tpl_adc_pack_compact #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_PATH_WIDTH = 1,
    parameter int BITS_PER_SAMPLE = 16,
    parameter int DMA_DATA_WIDTH  = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_CHANNELS-1:0]   enable,
    input  logic                      take,
    input  logic [DMA_DATA_WIDTH-1:0] data,
    output logic [DMA_DATA_WIDTH-1:0] chunk,
    output logic                      chunk_valid
);

    localparam int CDW = DATA_PATH_WIDTH * BITS_PER_SAMPLE;

    logic [DMA_DATA_WIDTH-1:0] compact_c;

    // Sample-major order: all enabled channels of sample 0, then of sample 1, ...
    always_comb begin
        int pos;
        compact_c = '0;
        pos = 0;
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (enable[ch]) begin
                    compact_c[pos*BITS_PER_SAMPLE +: BITS_PER_SAMPLE] =
                        data[CDW*ch + BITS_PER_SAMPLE*s +: BITS_PER_SAMPLE];
                    pos = pos + 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chunk       <= '0;
            chunk_valid <= 1'b0;
        end else begin
            chunk_valid <= take;
            if (take) begin
                chunk <= compact_c;
            end
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// Packs the enabled ADC channels into full DMA words: beat counter, accumulator,
// output register with valid/ready, plus sync, sticky overflow and config-error flags.
module ad_ip_jesd204_tpl_adc_pack #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_PATH_WIDTH = 1,
    parameter int BITS_PER_SAMPLE = 16,
    parameter int DMA_DATA_WIDTH  = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_CHANNELS-1:0]   enable,
    input  logic [NUM_CHANNELS-1:0]   adc_valid,
    input  logic [DMA_DATA_WIDTH-1:0] adc_data,
    output logic                      packed_valid,
    input  logic                      packed_ready,
    output logic [DMA_DATA_WIDTH-1:0] packed_data,
    output logic                      packed_sync,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic                      cfg_err
);

    // Output handshake: a word transfers on a rising clk edge where packed_valid and
    // packed_ready are both 1; packed_data/packed_sync stay stable while valid && !ready.

    localparam int CDW   = DATA_PATH_WIDTH * BITS_PER_SAMPLE;
    localparam int PC_W  = $clog2(NUM_CHANNELS + 1);
    localparam int CNT_W = $clog2(NUM_CHANNELS) + 1;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_CHANNELS-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic cfg_bad(input logic [NUM_CHANNELS-1:0] e);
        logic [PC_W-1:0] n;
        n = popcount(e);
        return (n == '0) || ((n & (n - PC_W'(1))) != '0);
    endfunction

    logic [NUM_CHANNELS-1:0]   enable_q;
    logic [CNT_W-1:0]          beat_cnt;
    logic [DMA_DATA_WIDTH-1:0] acc;
    logic                      sync_pending;
    logic [DMA_DATA_WIDTH-1:0] s1_chunk;
    logic                      s1_valid;

    logic                      change;
    logic                      take;
    logic                      write;
    logic                      last;
    logic                      complete;
    logic                      blocked;
    logic [PC_W-1:0]           n_act;
    logic [DMA_DATA_WIDTH-1:0] word_next;

    assign change  = (enable != enable_q);
    assign take    = (&adc_valid) && !change && !cfg_err;
    assign n_act   = popcount(enable_q);
    // A word is full once (beat_cnt+1) chunks of N channels cover all channels.
    assign last      = ((int'(beat_cnt) + 1) * int'(n_act)) == NUM_CHANNELS;
    assign word_next = acc | (s1_chunk << (int'(beat_cnt) * int'(n_act) * CDW));
    assign write     = s1_valid && !change && !cfg_err;
    assign complete  = write && last;
    assign blocked   = packed_valid && !packed_ready;

    ad_ip_jesd204_tpl_adc_pack_compact #(
        .NUM_CHANNELS    (NUM_CHANNELS),
        .DATA_PATH_WIDTH (DATA_PATH_WIDTH),
        .BITS_PER_SAMPLE (BITS_PER_SAMPLE),
        .DMA_DATA_WIDTH  (DMA_DATA_WIDTH)
    ) i_compact (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .take        (take),
        .data        (adc_data),
        .chunk       (s1_chunk),
        .chunk_valid (s1_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable_q     <= '0;
            cfg_err      <= 1'b0;
            beat_cnt     <= '0;
            acc          <= '0;
            sync_pending <= 1'b1;
            packed_valid <= 1'b0;
            packed_data  <= '0;
            packed_sync  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            enable_q <= enable;
            cfg_err  <= cfg_bad(enable);

            if (change || cfg_err) begin
                acc      <= '0;
                beat_cnt <= '0;
            end else if (write) begin
                if (last) begin
                    acc      <= '0;
                    beat_cnt <= '0;
                end else begin
                    acc      <= word_next;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end

            if (change) begin
                sync_pending <= 1'b1;
            end

            // A completing word reloads the output with no bubble unless the held word is stuck.
            if (complete && !blocked) begin
                packed_valid <= 1'b1;
                packed_data  <= word_next;
                packed_sync  <= sync_pending;
                sync_pending <= 1'b0;
            end else if (packed_ready) begin
                packed_valid <= 1'b0;
                packed_sync  <= 1'b0;
            end

            if (complete && blocked) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pack.sv
// Directed bench for the ADC channel packer: expected words go into a queue, a
// monitor pops and compares every accepted output word.
module tb_ad_ip_jesd204_tpl_adc_pack;

    localparam int NC = 4;
    localparam int W  = 64;

    logic          clk;
    logic          resetn;
    logic [NC-1:0] enable;
    logic [NC-1:0] adc_valid;
    logic [W-1:0]  adc_data;
    logic          packed_valid;
    logic          packed_ready;
    logic [W-1:0]  packed_data;
    logic          packed_sync;
    logic          overflow;
    logic          overflow_clr;
    logic          cfg_err;

    logic [W:0] exp_q[$];   // {sync, data}
    int compared;
    int mismatched;

    ad_ip_jesd204_tpl_adc_pack #(
        .NUM_CHANNELS    (4),
        .DATA_PATH_WIDTH (1),
        .BITS_PER_SAMPLE (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .packed_valid (packed_valid),
        .packed_ready (packed_ready),
        .packed_data  (packed_data),
        .packed_sync  (packed_sync),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .cfg_err      (cfg_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic send_beat(input logic [W-1:0] d);
        adc_valid = '1;
        adc_data  = d;
        step(1);
        adc_valid = '0;
    endtask

    task automatic set_enable(input logic [NC-1:0] e);
        enable = e;
        step(2);
    endtask

    task automatic expect_word(input logic sync, input logic [W-1:0] d);
        exp_q.push_back({sync, d});
    endtask

    // scoreboard monitor: inputs change just after posedge, so a negedge sample of
    // valid && ready is exactly the transfer of the following posedge
    always @(negedge clk) begin
        if (resetn && packed_valid && packed_ready) begin
            logic [W:0] e;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_word: got %h sync %0b expected none", packed_data, packed_sync);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", packed_data, e[W-1:0]);
                chk("word_sync", W'(packed_sync), W'(e[W]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        compared     = 0;
        mismatched   = 0;
        resetn       = 1'b0;
        enable       = '0;
        adc_valid    = '0;
        adc_data     = '0;
        packed_ready = 1'b1;
        overflow_clr = 1'b0;
        step(3);
        chk("rst_valid",    W'(packed_valid), 0);
        chk("rst_data",     packed_data,      0);
        chk("rst_sync",     W'(packed_sync),  0);
        chk("rst_overflow", W'(overflow),     0);
        chk("rst_cfg_err",  W'(cfg_err),      0);
        resetn = 1'b1;
        step(1);

        // 1: all channels, one beat per word, latency two cycles, sync on first word only
        set_enable(4'hF);
        expect_word(1'b1, 64'h4444_3333_2222_1111);
        send_beat(64'h4444_3333_2222_1111);
        chk("lat_t1_valid", W'(packed_valid), 0);
        step(1);
        chk("lat_t2_valid", W'(packed_valid), 1);
        chk("lat_t2_data",  packed_data, 64'h4444_3333_2222_1111);
        expect_word(1'b0, 64'h8888_7777_6666_5555);
        expect_word(1'b0, 64'hCCCC_BBBB_AAAA_9999);
        send_beat(64'h8888_7777_6666_5555);
        send_beat(64'hCCCC_BBBB_AAAA_9999);
        step(4);

        // 2: channels 0 and 2, two beats per word
        set_enable(4'h5);
        expect_word(1'b1, 64'hC1C1_A1A1_C0C0_A0A0);
        send_beat(64'h0D0D_C0C0_B0B0_A0A0);
        send_beat(64'h1D1D_C1C1_B1B1_A1A1);
        step(4);

        // 3: channel 0 only, four beats per word, with a gap and a partial-valid beat
        set_enable(4'h1);
        expect_word(1'b1, 64'h0004_0003_0002_0001);
        send_beat(64'hEEEE_DDDD_CCCC_0001);
        step(2);
        adc_valid = 4'b0111;
        adc_data  = 64'h0000_0000_0000_0BAD;
        step(1);
        adc_valid = '0;
        step(2);
        send_beat(64'hEEEE_DDDD_CCCC_0002);
        send_beat(64'hEEEE_DDDD_CCCC_0003);
        send_beat(64'hEEEE_DDDD_CCCC_0004);
        step(4);

        // 4: back-pressure, overflow, clear, delivery of the held word
        set_enable(4'hF);
        packed_ready = 1'b0;
        expect_word(1'b1, 64'h1111_2222_3333_4444);
        send_beat(64'h1111_2222_3333_4444);
        send_beat(64'h5555_6666_7777_8888);
        step(3);
        chk("ovf_valid_held", W'(packed_valid), 1);
        chk("ovf_data_held",  packed_data, 64'h1111_2222_3333_4444);
        chk("ovf_set",        W'(overflow), 1);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        chk("ovf_clr",        W'(overflow), 0);
        chk("ovf_data_kept",  packed_data, 64'h1111_2222_3333_4444);
        packed_ready = 1'b1;
        step(2);
        chk("ovf_drained_valid", W'(packed_valid), 0);

        // 5: illegal enables, then recovery with two channels
        enable = 4'h7;
        step(1);
        chk("cfg_err_7", W'(cfg_err), 1);
        send_beat(64'h9999_9999_9999_9999);
        step(3);
        chk("cfg_err_no_word", W'(packed_valid), 0);
        enable = 4'h0;
        step(1);
        chk("cfg_err_0", W'(cfg_err), 1);
        enable = 4'h3;
        step(1);
        chk("cfg_err_clear", W'(cfg_err), 0);
        step(1);
        expect_word(1'b1, 64'h4444_3333_2222_1111);
        send_beat(64'hFFFF_EEEE_2222_1111);
        send_beat(64'hFFFF_EEEE_4444_3333);
        step(4);

        // 6: reset mid-word drops the partial word
        set_enable(4'h1);
        send_beat(64'h0000_0000_0000_AAA1);
        send_beat(64'h0000_0000_0000_AAA2);
        step(1);
        resetn = 1'b0;
        step(1);
        chk("rst2_valid",    W'(packed_valid), 0);
        chk("rst2_data",     packed_data,      0);
        chk("rst2_sync",     W'(packed_sync),  0);
        chk("rst2_overflow", W'(overflow),     0);
        resetn = 1'b1;
        step(2);
        expect_word(1'b1, 64'h0044_0033_0022_0011);
        send_beat(64'h0000_0000_0000_0011);
        send_beat(64'h0000_0000_0000_0022);
        send_beat(64'h0000_0000_0000_0033);
        send_beat(64'h0000_0000_0000_0044);
        step(5);

        chk("queue_drained", W'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
